// File: rtl/rst_seq.sv
// Multi-channel reset sequencer: holds all domains in reset, then releases the
// active-low channel resets in a fixed staggered order with enable masking.
module rst_seq #(
    parameter int N_CH      = 4,
    parameter int PULSE_CYC = 16,
    parameter int STAGE_DLY = 8,
    parameter int CNT_W     = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            SwRst,
    input  logic [N_CH-1:0] ChEn,
    output logic [N_CH-1:0] Rst_n,
    output logic            Busy,
    output logic            Done
);

    localparam int IDX_W = (N_CH < 2) ? 1 : $clog2(N_CH + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DLY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_CH - 1);

    // Counter must hold the longest interval without wrapping.
    if (((2 ** CNT_W) <= PULSE_CYC) || ((2 ** CNT_W) <= STAGE_DLY)) begin : g_bad_cnt_w
        $error("rst_seq: CNT_W too small for PULSE_CYC/STAGE_DLY");
    end
    if ((N_CH < 1) || (PULSE_CYC < 1) || (STAGE_DLY < 1)) begin : g_bad_param
        $error("rst_seq: N_CH, PULSE_CYC and STAGE_DLY must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_IDLE    = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r,   cnt_s;
    logic [IDX_W-1:0]   idx_r,   idx_s;
    logic [N_CH-1:0]    rst_n_r, rst_n_s;
    logic               busy_r,  busy_s;
    logic               done_r,  done_s;

    // State and output registers, cleared asynchronously by the system reset.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_r <= ST_ASSERT;
            cnt_r   <= '0;
            idx_r   <= '0;
            rst_n_r <= '0;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            rst_n_r <= rst_n_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state logic; the software request overrides every transition.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        idx_s   = idx_r;
        rst_n_s = rst_n_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        if (SwRst) begin
            state_s = ST_ASSERT;
            cnt_s   = '0;
            idx_s   = '0;
            rst_n_s = '0;
            busy_s  = 1'b1;
        end else begin
            case (state_r)
                ST_ASSERT: begin
                    rst_n_s = '0;
                    busy_s  = 1'b1;
                    if (cnt_r == PULSE_LAST) begin
                        rst_n_s[0] = ChEn[0];
                        idx_s      = IDX_W'(1);
                        cnt_s      = '0;
                        if (N_CH == 1) begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_RELEASE: begin
                    // Released channels follow their enable; a masked channel still uses its slot.
                    for (int k = 0; k < N_CH; k++) begin
                        if ((k < int'(idx_r)) ||
                            ((k == int'(idx_r)) && (cnt_r == STAGE_LAST))) begin
                            rst_n_s[k] = ChEn[k];
                        end else begin
                            rst_n_s[k] = 1'b0;
                        end
                    end
                    if (cnt_r == STAGE_LAST) begin
                        cnt_s = '0;
                        idx_s = idx_r + IDX_W'(1);
                        if (idx_r == IDX_LAST) begin
                            state_s = ST_IDLE;
                            busy_s  = 1'b0;
                            done_s  = 1'b1;
                        end else begin
                            state_s = ST_RELEASE;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    rst_n_s = ChEn;
                    busy_s  = 1'b0;
                end
                default: begin
                    state_s = ST_ASSERT;
                    cnt_s   = '0;
                    idx_s   = '0;
                    rst_n_s = '0;
                    busy_s  = 1'b1;
                end
            endcase
        end
    end

    assign Rst_n = rst_n_r;
    assign Busy  = busy_r;
    assign Done  = done_r;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: default 4-channel instance plus a minimal
// single-channel instance, checked against hand-derived release edges.
module tb_rst_seq;

    logic       clk;
    logic       rst;
    logic       sw_rst;
    logic [3:0] ch_en;
    logic [3:0] rst_n;
    logic       busy;
    logic       done;

    logic       sw_rst1;
    logic [0:0] ch_en1;
    logic [0:0] rst_n1;
    logic       busy1;
    logic       done1;

    int n_tests = 0;
    int n_fail  = 0;

    rst_seq dut (
        .Clk(clk), .Rst(rst), .SwRst(sw_rst), .ChEn(ch_en),
        .Rst_n(rst_n), .Busy(busy), .Done(done)
    );

    rst_seq #(.N_CH(1), .PULSE_CYC(1), .STAGE_DLY(1), .CNT_W(1)) dut1 (
        .Clk(clk), .Rst(rst), .SwRst(sw_rst1), .ChEn(ch_en1),
        .Rst_n(rst_n1), .Busy(busy1), .Done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected channel state at edge e after the start of a sequence (all enabled).
    function automatic logic [3:0] exp_rn(input int e);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = (e >= 16 + 8 * k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rst high for 3 cycles, dropped mid-cycle so the next edge is edge 1.
    task automatic apply_reset();
        rst = 1'b1;
        sw_rst = 1'b0;
        sw_rst1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sw_rst = 1'b0; sw_rst1 = 1'b0; ch_en = 4'hF; ch_en1 = 1'b1; rst = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: Rst_n=%b Busy=%b Done=%b, want 0000 1 0", rst_n, busy, done);
        end
        n_tests++;
        if (rst_n1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async_min: Rst_n=%b Busy=%b Done=%b, want 0 1 0", rst_n1, busy1, done1);
        end
    endtask

    task automatic test_power_up();
        ch_en = 4'hF;
        apply_reset();
        for (int e = 1; e <= 42; e++) begin
            tick();
            n_tests++;
            if (rst_n !== exp_rn(e) || busy !== 1'(e < 40) || done !== 1'(e == 40)) begin
                n_fail++;
                $display("FAIL power_up edge %0d: Rst_n=%b Busy=%b Done=%b, want %b %b %b",
                         e, rst_n, busy, done, exp_rn(e), 1'(e < 40), 1'(e == 40));
            end
        end
    endtask

    task automatic test_async_mid_release();
        ch_en = 4'hF;
        apply_reset();
        repeat (28) tick();
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_release_async: Rst_n=%b Busy=%b Done=%b, want 0000 1 0", rst_n, busy, done);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int e = 1; e <= 41; e++) begin
            tick();
            n_tests++;
            if (rst_n !== exp_rn(e) || busy !== 1'(e < 40) || done !== 1'(e == 40)) begin
                n_fail++;
                $display("FAIL restart edge %0d: Rst_n=%b Busy=%b Done=%b, want %b %b %b",
                         e, rst_n, busy, done, exp_rn(e), 1'(e < 40), 1'(e == 40));
            end
        end
    endtask

    task automatic test_mask();
        ch_en = 4'b1011;
        apply_reset();
        for (int e = 1; e <= 42; e++) begin
            tick();
            n_tests++;
            if (rst_n !== (exp_rn(e) & 4'b1011) || busy !== 1'(e < 40) || done !== 1'(e == 40)) begin
                n_fail++;
                $display("FAIL mask edge %0d: Rst_n=%b Busy=%b Done=%b, want %b %b %b",
                         e, rst_n, busy, done, exp_rn(e) & 4'b1011, 1'(e < 40), 1'(e == 40));
            end
        end
        ch_en = 4'b1111;
        n_tests++;
        if (rst_n !== 4'b1011) begin
            n_fail++;
            $display("FAIL mask_no_comb_path: Rst_n=%b, want 1011", rst_n);
        end
        tick();
        n_tests++;
        if (rst_n !== 4'b1111) begin
            n_fail++;
            $display("FAIL mask_enable_idle: Rst_n=%b, want 1111", rst_n);
        end
        ch_en = 4'b1101;
        tick();
        n_tests++;
        if (rst_n !== 4'b1101 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_clear_idle: Rst_n=%b Busy=%b Done=%b, want 1101 0 0", rst_n, busy, done);
        end
        ch_en = 4'hF;
    endtask

    task automatic test_swrst_idle();
        ch_en = 4'hF;
        apply_reset();
        repeat (45) tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        n_tests++;
        if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL swrst_idle_edge_S: Rst_n=%b Busy=%b Done=%b, want 0000 1 0", rst_n, busy, done);
        end
        for (int e = 1; e <= 41; e++) begin
            tick();
            n_tests++;
            if (rst_n !== exp_rn(e) || busy !== 1'(e < 40) || done !== 1'(e == 40)) begin
                n_fail++;
                $display("FAIL swrst_idle S+%0d: Rst_n=%b Busy=%b Done=%b, want %b %b %b",
                         e, rst_n, busy, done, exp_rn(e), 1'(e < 40), 1'(e == 40));
            end
        end
    endtask

    task automatic test_swrst_mid(input int hold);
        ch_en = 4'hF;
        apply_reset();
        repeat (19) tick();
        sw_rst = 1'b1;
        for (int h = 0; h < hold; h++) begin
            tick();
            n_tests++;
            if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
                n_fail++;
                $display("FAIL swrst_hold%0d edge %0d: Rst_n=%b Busy=%b Done=%b, want 0000 1 0",
                         hold, 20 + h, rst_n, busy, done);
            end
        end
        sw_rst = 1'b0;
        for (int e = 1; e <= 41; e++) begin
            tick();
            n_tests++;
            if (rst_n !== exp_rn(e) || busy !== 1'(e < 40) || done !== 1'(e == 40)) begin
                n_fail++;
                $display("FAIL swrst_hold%0d edge %0d: Rst_n=%b Busy=%b Done=%b, want %b %b %b",
                         hold, 19 + hold + e, rst_n, busy, done, exp_rn(e), 1'(e < 40), 1'(e == 40));
            end
        end
    endtask

    task automatic test_back_to_back();
        ch_en = 4'hF;
        apply_reset();
        repeat (39) tick();
        sw_rst = 1'b1;
        tick();
        sw_rst = 1'b0;
        n_tests++;
        if (rst_n !== 4'b0000 || busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL swrst_on_idle_entry: Rst_n=%b Busy=%b Done=%b, want 0000 1 0", rst_n, busy, done);
        end
        tick();
        n_tests++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL swrst_on_idle_entry_next: Busy=%b Done=%b, want 1 0", busy, done);
        end
    endtask

    task automatic test_min_params();
        ch_en1 = 1'b1;
        apply_reset();
        n_tests++;
        if (rst_n1 !== 1'b0 || busy1 !== 1'b1 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL min_reset: Rst_n=%b Busy=%b Done=%b, want 0 1 0", rst_n1, busy1, done1);
        end
        tick();
        n_tests++;
        if (rst_n1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b1) begin
            n_fail++;
            $display("FAIL min_edge1: Rst_n=%b Busy=%b Done=%b, want 1 0 1", rst_n1, busy1, done1);
        end
        tick();
        n_tests++;
        if (rst_n1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
            n_fail++;
            $display("FAIL min_edge2: Rst_n=%b Busy=%b Done=%b, want 1 0 0", rst_n1, busy1, done1);
        end
        ch_en1 = 1'b0;
        tick();
        n_tests++;
        if (rst_n1 !== 1'b0) begin
            n_fail++;
            $display("FAIL min_mask_idle: Rst_n=%b, want 0", rst_n1);
        end
        ch_en1 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_async_mid_release();
        test_mask();
        test_swrst_idle();
        test_swrst_mid(1);
        test_swrst_mid(5);
        test_back_to_back();
        test_min_params();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Parametrised multi-channel reset sequencer for the I2C functional-model benches and RTL top levels. One asynchronous active-high system reset holds every downstream domain in reset. The block then releases N_CH active-low channel resets in a fixed staggered order, each separated by a programmable gap. It also supports a software-requested re-reset and a per-channel enable mask, and reports Busy/Done status.

## Interface
- N_CH, 4: number of reset output channels (≥1).
- PULSE_CYC, 16: minimum assertion length in Clk cycles, measured before channel 0 is released (≥1).
- STAGE_DLY, 8: Clk cycles between release of channel k and channel k+1 (≥1).
- CNT_W, 8: cycle-counter width. Required: 2^CNT_W > max(PULSE_CYC, STAGE_DLY). Elaboration fails otherwise.

- Clk  in  1  system clock, rising-edge active.
- Rst  in  1  system reset; asynchronous, active-high.
- SwRst  in  1  software reset request, sampled on Clk rising edge, level-qualified.
- ChEn  in  N_CH  per-channel enable; 0 holds that channel in reset.
- Rst_n  out  N_CH  channel resets, active-low; bit k drives domain k.
- Busy  out  1  high while the sequence is in progress (ASSERT or RELEASE).
- Done  out  1  one-cycle pulse when the sequence completes.

## Operation
- All flops use asynchronous reset on Rst. While Rst=1: state=ASSERT, cnt=0, idx=0, Rst_n=all 0, Busy=1, Done=0. All of these are reached immediately, without waiting for Clk.
- **ASSERT:**
  - All Rst_n=0; cnt increments each edge.
  - On the edge where cnt==PULSE_CYC-1: Rst_n[0]<=ChEn[0], idx<=1, cnt<=0.
  - If N_CH==1, the next state is IDLE. Otherwise the next state is RELEASE.
- **RELEASE:** cnt increments each edge. On the edge where cnt==STAGE_DLY-1:
  - Rst_n[idx]<=ChEn[idx], cnt<=0, idx<=idx+1.
  - If idx==N_CH-1, the next state is IDLE.
- **Leaving for IDLE:** on the transition edge, Busy<=0 and Done<=1 (Done lasts one cycle).
- **IDLE:** Rst_n[k]<=ChEn[k] each edge.
  - Clearing an enable bit re-asserts that channel one edge later.
  - Setting it releases that channel one edge later. This is the only unsequenced release.
- **Already released channels:** they track ChEn[k] the same way during RELEASE. Channels not yet released stay at 0 regardless of ChEn.
- **Masked channels:** a channel with ChEn=0 still consumes its stage slot, so release timing of the other channels never depends on the mask.
- **SwRst=1 on any edge, in any state:**
  - state<=ASSERT, cnt<=0, idx<=0, Rst_n<=all 0, Busy<=1, Done<=0.
  - This restarts the sequence. SwRst has priority over every other transition, including the IDLE-entry edge (no Done pulse in that case).
  - SwRst held high keeps the block in ASSERT with cnt=0.

## Timing
- Edge 1 is the first Clk rising edge at which Rst=0 and SwRst=0.
- Rst_n[k] rises (if ChEn[k]=1) at edge PULSE_CYC + k·STAGE_DLY.
- Busy falls and Done rises at edge PULSE_CYC + (N_CH-1)·STAGE_DLY. Done falls one edge later.
- Defaults give release edges 16, 24, 32, 40, with Done high for the cycle after edge 40.
- After a SwRst sample at edge S with SwRst=0 from S+1 onward, Rst_n[k] rises at S + PULSE_CYC + k·STAGE_DLY.
- Assertion is asynchronous only via Rst. SwRst and ChEn assertion take effect at the sampling edge, with outputs registered.
- Deassertion is always synchronous to Clk. No output glitches: every output comes directly from a flop.
- cnt never exceeds max(PULSE_CYC, STAGE_DLY)-1, so no wrap-around occurs.

## Test plan
- Defaults, ChEn=4'hF, Rst pulsed for 3 cycles then low → Rst_n 0000 until edge 16. Then 0001@16, 0011@24, 0111@32, 1111@40. Busy falls @40 and Done=1 for exactly one cycle.
- Rst asserted mid-RELEASE (after edge 28, between clock edges) → Rst_n=0000, Busy=1, Done=0 immediately, without a Clk edge. Full sequence restarts on release.
- ChEn=4'b1011 during power-up → Rst_n[2] stays 0 throughout. Channel 3 still releases @40 and Done fires @40. Setting ChEn[2]=1 in IDLE → Rst_n[2]=1 one edge later.
- SwRst one-cycle pulse in IDLE at edge S → all Rst_n=0 at S, Busy=1. Releases at S+16/24/32/40, Done at S+40.
- SwRst at edge 20 (channel 0 released) → Rst_n=0000 at 20. New releases at 36/44/52/60 with no Done before 60. SwRst held 5 cycles → releases shift by a further 4.
- Params N_CH=1, PULSE_CYC=1, STAGE_DLY=1 → Rst_n[0] rises at edge 1 with Busy↓/Done↑ same edge. CNT_W=3 with PULSE_CYC=8 → elaboration error.
